i2s_rx_stereo: RTL and testbench
================================

// Module: i2s_rx_stereo
// PURPOSE
//  Parametrised stereo I2S/left-justified serial receiver, clocked by the codec bit
//  clock. Deserialises both channels of each frame and presents them as an aligned
//  signed sample pair. Flags malformed (short) slots. Feeds the effects datapath.
// PARAMETERS
//  DATA_W    24  sample width in bits; 8..32; MSB-first on the wire
//  MODE      0   0 = I2S (MSB one sclk after lrclk edge), 1 = left-justified (MSB on edge)
//  LEFT_LOW  1   1 = lrclk low is left channel; 0 = lrclk high is left channel
// PORTS
//  sclk        in   1       bit clock; all logic on rising edge
//  rst         in   1       asynchronous reset, active high
//  lrclk       in   1       word select; sampled on sclk rising edge
//  sdin        in   1       serial data; sampled on sclk rising edge
//  left_data   out  DATA_W  signed left sample, updated with dvalid
//  right_data  out  DATA_W  signed right sample, updated with dvalid
//  dvalid      out  1       1-cycle pulse: new left/right pair on outputs
//  frame_err   out  1       1-cycle pulse: slot ended before DATA_W bits received
// BEHAVIOUR
//  Reset: left_data=0, right_data=0, dvalid=0, frame_err=0, left staging=0,
//   state=IDLE, prev_lr=0, primed=0, bit count=0. Reset mid-word discards partial data.
//  Edge detect: prev_lr <= lrclk every cycle; edge = primed & (prev_lr ^ lrclk).
//   primed sets on first cycle after reset, so no false edge from prev_lr reset value.
//  Slot channel = lrclk value at the edge, mapped through LEFT_LOW.
//  States:
//   IDLE  - ignore sdin; on edge -> SHIFT (waits for a full slot; no partial output).
//   SHIFT - shift sdin into shreg MSB-first, count++. MODE=1: edge-cycle sdin is the
//           MSB (count=1 after edge). MODE=0: edge-cycle sdin is not data; MSB next cycle.
//           count reaches DATA_W -> commit word, -> HOLD.
//   HOLD  - extra slot bits (slot > DATA_W) ignored; on edge -> SHIFT for new slot.
//  Commit: left slot -> staging reg. Right slot -> left_data<=staging,
//   right_data<=word, dvalid=1 next cycle. A right slot with no left slot completed
//   earlier in the frame (e.g. first slot after reset is right) produces no dvalid.
//  Short slot: edge while SHIFT and count<DATA_W -> frame_err=1 one cycle, partial
//   discarded, staging invalidated (no dvalid for that frame), new slot starts normally.
//  Exact-fit MODE=0 (slot == DATA_W): LSB arrives on the cycle of the next edge; that
//   bit completes and commits the word (no frame_err) and the new slot starts on the
//   same cycle. Commit has priority over error.
//  Latency: dvalid asserted on the cycle after the right LSB is sampled.
//  Outputs hold between dvalid pulses. dvalid and frame_err never both high.
//  Width: count is $clog2(DATA_W+1) bits, saturates in HOLD; no sign extension.
// STRUCTURE
//  i2s_pkg: i2s_mode_e {I2S_PHILIPS=0, I2S_LJ=1}; rx_state_e {IDLE,SHIFT,HOLD};
//   shared with the future i2s transmitter.
//  Single module; edge detect, FSM, shift reg and staging are inline. No sub-module.
// TESTING
//  T1 DATA_W=24, MODE=0, 32-bit slots, L=24'h123456, R=24'hFEDCBA -> one dvalid,
//     left_data=24'h123456, right_data=24'hFEDCBA (negative), frame_err=0.
//  T2 MODE=1, 32-bit slots, L=24'h800000, R=24'h7FFFFF -> pair exact. One-bit
//     misalignment vs. MODE=0 is checked on the same stimulus.
//  T3 MODE=0, 24-bit slots (exact fit), 4 back-to-back frames of random data ->
//     4 dvalid pulses, all pairs correct, no frame_err.
//  T4 MODE=0, 16-bit left slot then valid 32-bit right -> frame_err pulse at left-slot
//     end, no dvalid for that frame; next full frame -> normal dvalid.
//  T5 rst asserted mid-right-word, released -> outputs 0; first slot after release is
//     discarded; first complete L+R frame -> dvalid with correct data.
//  T6 LEFT_LOW=0, L=24'h000001, R=24'hFFFFFF -> channel mapping swapped correctly.

Source files
------------

// File: rtl/i2s_rx_stereo_pkg.sv
// i2s_pkg: types shared by the I2S receiver and the future I2S transmitter.
//   i2s_mode_e  - wire framing: Philips I2S (MSB one sclk after the lrclk edge)
//                 or left-justified (MSB on the edge cycle)
//   rx_state_e  - receiver slot state
//   cnt_w()     - width of a bit counter that must hold 0..data_w inclusive
package i2s_pkg;

  typedef enum logic {
    I2S_PHILIPS = 1'b0,
    I2S_LJ      = 1'b1
  } i2s_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_stereo_if.sv
// i2s_rx_stereo_if: serial-side inputs and parallel-side outputs of the stereo
// I2S receiver. sclk/rst are kept as plain module ports.
//   lrclk, sdin               serial word select and data (master drives)
//   left_data, right_data     signed sample pair (slave drives)
//   dvalid                    1-cycle pulse: new pair on left/right_data
//   frame_err                 1-cycle pulse: a slot ended short
// Modports: master = codec/stimulus side, slave = receiver.
interface i2s_rx_stereo_if #(
  parameter int DATA_W = 24
);
  logic                     lrclk;
  logic                     sdin;
  logic signed [DATA_W-1:0] left_data;
  logic signed [DATA_W-1:0] right_data;
  logic                     dvalid;
  logic                     frame_err;

  modport master (
    output lrclk, sdin,
    input  left_data, right_data, dvalid, frame_err
  );

  modport slave (
    input  lrclk, sdin,
    output left_data, right_data, dvalid, frame_err
  );
endinterface

// File: rtl/i2s_rx_stereo.sv
// i2s_rx_stereo: stereo I2S / left-justified deserialiser clocked by the codec
// bit clock. Collects one DATA_W word per lrclk slot, stages the left word and
// presents the left/right pair together with a one-cycle dvalid after the right
// word's LSB. A slot that ends before DATA_W bits pulses frame_err and drops the
// frame.
// Ports:
//   sclk  in  bit clock, all logic on its rising edge
//   rst   in  asynchronous reset, active high
//   bus   slave modport of i2s_rx_stereo_if (lrclk, sdin in; sample pair,
//         dvalid, frame_err out). bus DATA_W must equal DATA_W here.
// Parameters: DATA_W 8..32, MODE 0=I2S / 1=left-justified, LEFT_LOW 1 = lrclk
// low selects the left channel.
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int MODE     = 0,
  parameter int LEFT_LOW = 1
) (
  input  logic           sclk,
  input  logic           rst,
  i2s_rx_stereo_if.slave bus
);

  localparam int            CW        = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST      = CW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL      = CW'(DATA_W);
  localparam bit            LJ        = (MODE == int'(I2S_LJ));
  // Left-justified consumes the MSB on the edge cycle itself.
  localparam logic [CW-1:0] START_CNT = LJ ? CW'(1) : CW'(0);

  rx_state_e          state;
  logic               prev_lr;
  logic               primed;
  logic               slot_left;
  logic               stg_vld;
  logic [DATA_W-2:0]  shreg;
  logic [DATA_W-1:0]  staging;
  logic [DATA_W-1:0]  left_q;
  logic [DATA_W-1:0]  right_q;
  logic [CW-1:0]      cnt;
  logic               dvalid_q;
  logic               ferr_q;

  logic               lr_edge;
  logic               edge_left;
  logic [DATA_W-1:0]  word;
  logic               commit;

  // primed masks the first cycle so the reset value of prev_lr cannot fake an edge.
  assign lr_edge   = primed & (prev_lr ^ bus.lrclk);
  assign edge_left = (LEFT_LOW != 0) ? ~bus.lrclk : bus.lrclk;
  assign word      = {shreg, bus.sdin};

  // The bit that fills the word commits it. In I2S an exact-fit slot delivers
  // its LSB on the next slot's edge cycle, so commit wins over the short-slot
  // error there. In LJ the edge-cycle bit belongs to the new slot.
  assign commit    = (state == SHIFT) && (cnt == LAST) && !(lr_edge && LJ);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev_lr   <= 1'b0;
      primed    <= 1'b0;
      slot_left <= 1'b0;
      stg_vld   <= 1'b0;
      shreg     <= '0;
      staging   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      cnt       <= '0;
      dvalid_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      prev_lr  <= bus.lrclk;
      primed   <= 1'b1;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;

      case (state)
        // IDLE waits for the first full slot; HOLD ignores slot padding bits.
        IDLE, HOLD: begin
          if (lr_edge) begin
            state     <= SHIFT;
            slot_left <= edge_left;
            shreg     <= word[DATA_W-2:0];
            cnt       <= START_CNT;
          end
        end

        SHIFT: begin
          shreg <= word[DATA_W-2:0];

          if (commit) begin
            if (slot_left) begin
              staging <= word;
              stg_vld <= 1'b1;
            end else begin
              // A right word only completes a frame if its left word made it.
              if (stg_vld) begin
                left_q   <= staging;
                right_q  <= word;
                dvalid_q <= 1'b1;
              end
              stg_vld <= 1'b0;
            end
          end else if (lr_edge) begin
            ferr_q  <= 1'b1;
            stg_vld <= 1'b0;
          end

          if (lr_edge) begin
            slot_left <= edge_left;
            cnt       <= START_CNT;
          end else if (commit) begin
            state <= HOLD;
            cnt   <= FULL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.left_data  = left_q;
  assign bus.right_data = right_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Bench for i2s_rx_stereo. Three receivers share one serial stream:
//   0: MODE=0 LEFT_LOW=1   1: MODE=1 LEFT_LOW=1   2: MODE=0 LEFT_LOW=0
// Streams are built slot by slot; the reference model re-segments the lrclk
// trace into slots and derives the expected dvalid/frame_err events from the
// slot-level rules (slot length, data offset, channel pairing).
module tb_i2s_rx_stereo;

  localparam int W = 24;

  // {kind(1=frame_err), sample index(16), left(24), right(24)}
  typedef logic [64:0] ev_t;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic lr   = 1'b0;
  logic sd   = 1'b0;

  always #5 sclk = ~sclk;

  i2s_rx_stereo_if #(.DATA_W(W)) ifa ();
  i2s_rx_stereo_if #(.DATA_W(W)) ifb ();
  i2s_rx_stereo_if #(.DATA_W(W)) ifc ();

  assign ifa.lrclk = lr;  assign ifa.sdin = sd;
  assign ifb.lrclk = lr;  assign ifb.sdin = sd;
  assign ifc.lrclk = lr;  assign ifc.sdin = sd;

  i2s_rx_stereo #(.DATA_W(W), .MODE(0), .LEFT_LOW(1)) dut_a (.sclk(sclk), .rst(rst), .bus(ifa.slave));
  i2s_rx_stereo #(.DATA_W(W), .MODE(1), .LEFT_LOW(1)) dut_b (.sclk(sclk), .rst(rst), .bus(ifb.slave));
  i2s_rx_stereo #(.DATA_W(W), .MODE(0), .LEFT_LOW(0)) dut_c (.sclk(sclk), .rst(rst), .bus(ifc.slave));

  logic [2:0]   dv, fe;
  logic [W-1:0] ld [3];
  logic [W-1:0] rd [3];
  assign dv = {ifc.dvalid, ifb.dvalid, ifa.dvalid};
  assign fe = {ifc.frame_err, ifb.frame_err, ifa.frame_err};
  assign ld[0] = ifa.left_data;  assign rd[0] = ifa.right_data;
  assign ld[1] = ifb.left_data;  assign rd[1] = ifb.right_data;
  assign ld[2] = ifc.left_data;  assign rd[2] = ifc.right_data;

  // Data offset of the MSB from the slot edge, and channel polarity, per DUT.
  int off_of [3] = '{1, 0, 1};
  bit ll_of  [3] = '{1'b1, 1'b1, 1'b0};

  int  n_chk   = 0;
  int  n_pass  = 0;
  int  both_hi = 0;

  bit  lr_s [$];
  bit  sd_s [$];
  int  ov_i [$];
  bit  ov_b [$];
  ev_t obs_q [3][$];

  // ---------------- stream construction ----------------
  task automatic new_stream(input bit l, input int len);
    lr_s.delete(); sd_s.delete(); ov_i.delete(); ov_b.delete();
    for (int i = 0; i < len; i++) begin
      lr_s.push_back(l);
      sd_s.push_back(1'($urandom));
    end
  endtask

  // Data bits land at slot offset off..off+W-1; a short slot only carries
  // as many bits as it is long, the rest of each slot is random filler.
  task automatic add_slot(input bit l, input int len, input logic [W-1:0] w, input int off);
    int s;
    s = lr_s.size();
    for (int i = 0; i < len; i++) begin
      lr_s.push_back(l);
      sd_s.push_back(1'($urandom));
    end
    for (int k = 0; k < W && k < len; k++) begin
      ov_i.push_back(s + off + k);
      ov_b.push_back(w[W-1-k]);
    end
  endtask

  task automatic end_stream(input int len);
    bit l;
    l = !lr_s[lr_s.size()-1];
    for (int i = 0; i < len; i++) begin
      lr_s.push_back(l);
      sd_s.push_back(1'($urandom));
    end
    for (int j = 0; j < ov_i.size(); j++)
      if (ov_i[j] < sd_s.size()) sd_s[ov_i[j]] = ov_b[j];
  endtask

  // ---------------- drive / observe ----------------
  task automatic do_reset();
    rst = 1'b1; lr = 1'b0; sd = 1'b0;
    repeat (2) @(posedge sclk);
    #1 rst = 1'b0;
  endtask

  // Sample i is taken at the i-th rising edge; an event seen just after that
  // edge is recorded with index i.
  task automatic play();
    for (int d = 0; d < 3; d++) obs_q[d].delete();
    for (int i = 0; i < lr_s.size(); i++) begin
      lr = lr_s[i];
      sd = sd_s[i];
      @(posedge sclk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (dv[d]) obs_q[d].push_back({1'b0, 16'(i), ld[d], rd[d]});
        if (fe[d]) obs_q[d].push_back({1'b1, 16'(i), 48'd0});
        if (dv[d] && fe[d]) both_hi++;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Slots run between lrclk transitions (none counted on the first sample
  // after reset). A slot shorter than W flags an error at the next transition
  // and kills any staged left word. A full slot yields W bits starting at the
  // DUT's offset; the last of them is the commit sample. Left words stage,
  // right words pair with a staged left word.
  task automatic model(input int d, output ev_t q[$]);
    int           e [$];
    int           n, s, last;
    bit           staged, is_left;
    logic [W-1:0] stg, w;
    q.delete();
    n = lr_s.size();
    staged = 1'b0;
    stg = '0;
    for (int i = 1; i < n; i++) if (lr_s[i] != lr_s[i-1]) e.push_back(i);
    for (int j = 0; j < e.size(); j++) begin
      s       = e[j];
      last    = s + off_of[d] + W - 1;
      is_left = ll_of[d] ? !lr_s[s] : lr_s[s];
      if (j + 1 < e.size() && e[j+1] - s < W) begin
        q.push_back({1'b1, 16'(e[j+1]), 48'd0});
        staged = 1'b0;
      end else if (last < n) begin
        for (int k = 0; k < W; k++) w[W-1-k] = sd_s[s + off_of[d] + k];
        if (is_left) begin
          stg = w;
          staged = 1'b1;
        end else if (staged) begin
          q.push_back({1'b0, 16'(last), stg, w});
          staged = 1'b0;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ev_t exp_q [$];
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({dv[d], fe[d], ld[d], rd[d]} !== 50'd0)
        $display("FAIL reset dut%0d: got dv=%b fe=%b l=%h r=%h, want all zero", d, dv[d], fe[d], ld[d], rd[d]);
      else n_pass++;
    end
    do_reset();
    // lrclk high straight out of reset must not count as an edge.
    new_stream(1'b1, 30);
    add_slot(1'b0, 32, W'($urandom), 1);
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL reset_prime dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL reset_prime dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_i2s_basic();
    ev_t exp_q [$];
    do_reset();
    new_stream(1'b1, 3);
    add_slot(1'b0, 32, 24'h123456, 1);
    add_slot(1'b1, 32, 24'hFEDCBA, 1);
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL i2s_basic dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL i2s_basic dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
    n_chk++;
    if (ld[0] !== 24'h123456 || rd[0] !== 24'hFEDCBA || !($signed(rd[0]) < 0))
      $display("FAIL i2s_basic pair: got l=%h r=%h want l=123456 r=fedcba (negative)", ld[0], rd[0]);
    else n_pass++;
  endtask

  task automatic test_lj_align();
    ev_t exp_q [$];
    do_reset();
    new_stream(1'b1, 3);
    add_slot(1'b0, 32, 24'h800000, 0);
    add_slot(1'b1, 32, 24'h7FFFFF, 0);
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL lj_align dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL lj_align dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
    n_chk++;
    if (ld[1] !== 24'h800000 || rd[1] !== 24'h7FFFFF)
      $display("FAIL lj_pair: got l=%h r=%h want l=800000 r=7fffff", ld[1], rd[1]);
    else n_pass++;
    // I2S framing on the same wire reads every word one bit late.
    n_chk++;
    if (ld[0][W-1:1] !== 23'h000000 || rd[0][W-1:1] !== 23'h7FFFFF)
      $display("FAIL lj_vs_i2s_shift: got l=%h r=%h want l[23:1]=0 r[23:1]=7fffff", ld[0], rd[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    ev_t exp_q [$];
    int  nd, ne;
    do_reset();
    both_hi = 0;
    new_stream(1'b1, 3);
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, W, W'($urandom), 1);
      add_slot(1'b1, W, W'($urandom), 1);
    end
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL back_to_back dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL back_to_back dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
    nd = 0; ne = 0;
    for (int k = 0; k < obs_q[0].size(); k++) if (obs_q[0][k][64]) ne++; else nd++;
    n_chk++;
    if (nd !== 4 || ne !== 0) $display("FAIL back_to_back counts: got dvalid=%0d err=%0d want 4 and 0", nd, ne);
    else n_pass++;
    n_chk++;
    if (both_hi !== 0) $display("FAIL dvalid_and_err_together: got %0d cycles want 0", both_hi);
    else n_pass++;
  endtask

  task automatic test_short_slot();
    ev_t          exp_q [$];
    logic [W-1:0] wl1, wr1;
    wl1 = W'($urandom);
    wr1 = W'($urandom);
    do_reset();
    new_stream(1'b1, 3);
    add_slot(1'b0, 16, W'($urandom), 1);
    add_slot(1'b1, 32, W'($urandom), 1);
    add_slot(1'b0, 32, wl1, 1);
    add_slot(1'b1, 32, wr1, 1);
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL short_slot dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL short_slot dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
    // Left slot starts at sample 3 and lasts 16 samples -> error at sample 19.
    n_chk++;
    if (obs_q[0].size() < 1 || obs_q[0][0] !== {1'b1, 16'd19, 48'd0})
      $display("FAIL short_slot err_pos: got n=%0d first=%h want err at sample 19", obs_q[0].size(),
               (obs_q[0].size() > 0) ? obs_q[0][0] : ev_t'(0));
    else n_pass++;
    n_chk++;
    if (ld[0] !== wl1 || rd[0] !== wr1)
      $display("FAIL short_slot recovery: got l=%h r=%h want l=%h r=%h", ld[0], rd[0], wl1, wr1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    ev_t          exp_q [$];
    logic [W-1:0] wl, wr;
    wl = W'($urandom);
    wr = W'($urandom);
    do_reset();
    new_stream(1'b1, 3);
    add_slot(1'b0, 32, 24'h3C3C3C, 1);
    add_slot(1'b1, 32, 24'hC3C3C3, 1);
    add_slot(1'b0, 32, W'($urandom), 1);
    add_slot(1'b1, 12, W'($urandom), 1);
    end_stream(0);
    play();
    n_chk++;
    if (ld[0] !== 24'h3C3C3C || rd[0] !== 24'hC3C3C3)
      $display("FAIL reset_mid pre: got l=%h r=%h want l=3c3c3c r=c3c3c3", ld[0], rd[0]);
    else n_pass++;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({dv[d], fe[d], ld[d], rd[d]} !== 50'd0)
        $display("FAIL reset_mid clear dut%0d: got l=%h r=%h dv=%b fe=%b want zero", d, ld[d], rd[d], dv[d], fe[d]);
      else n_pass++;
    end
    repeat (2) @(posedge sclk);
    #1 rst = 1'b0;
    // The tail of the interrupted right slot is still on the wire after release.
    new_stream(1'b1, 10);
    add_slot(1'b0, 32, wl, 1);
    add_slot(1'b1, 32, wr, 1);
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL reset_mid dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL reset_mid dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
    n_chk++;
    if (ld[0] !== wl || rd[0] !== wr)
      $display("FAIL reset_mid post: got l=%h r=%h want l=%h r=%h", ld[0], rd[0], wl, wr);
    else n_pass++;
  endtask

  task automatic test_left_high();
    ev_t exp_q [$];
    do_reset();
    new_stream(1'b0, 3);
    add_slot(1'b1, 32, 24'h000001, 1);
    add_slot(1'b0, 32, 24'hFFFFFF, 1);
    end_stream(4);
    play();
    for (int d = 0; d < 3; d++) begin
      model(d, exp_q);
      n_chk++;
      if (obs_q[d].size() !== exp_q.size())
        $display("FAIL left_high dut%0d events: got %0d want %0d", d, obs_q[d].size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
        n_chk++;
        if (obs_q[d][k] !== exp_q[k]) $display("FAIL left_high dut%0d ev%0d: got %h want %h", d, k, obs_q[d][k], exp_q[k]);
        else n_pass++;
      end
    end
    n_chk++;
    if (ld[2] !== 24'h000001 || rd[2] !== 24'hFFFFFF || obs_q[2].size() !== 1)
      $display("FAIL left_high pair: got l=%h r=%h n=%0d want l=000001 r=ffffff n=1", ld[2], rd[2], obs_q[2].size());
    else n_pass++;
  endtask

  task automatic test_random();
    ev_t exp_q [$];
    bit  l;
    for (int off = 0; off < 2; off++) begin
      for (int rep = 0; rep < 3; rep++) begin
        do_reset();
        l = 1'($urandom);
        new_stream(l, 2 + $urandom_range(0, 6));
        for (int s = 0; s < 8; s++) begin
          l = !l;
          add_slot(l, $urandom_range(18, 34), W'($urandom), off);
        end
        end_stream(4);
        play();
        for (int d = 0; d < 3; d++) begin
          model(d, exp_q);
          n_chk++;
          if (obs_q[d].size() !== exp_q.size())
            $display("FAIL random off%0d dut%0d events: got %0d want %0d", off, d, obs_q[d].size(), exp_q.size());
          else n_pass++;
          for (int k = 0; k < exp_q.size() && k < obs_q[d].size(); k++) begin
            n_chk++;
            if (obs_q[d][k] !== exp_q[k]) $display("FAIL random off%0d dut%0d ev%0d: got %h want %h", off, d, k, obs_q[d][k], exp_q[k]);
            else n_pass++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_i2s_basic();
    test_lj_align();
    test_back_to_back();
    test_short_slot();
    test_reset_mid();
    test_left_high();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
